// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, controller state type and datapath select encodings for multicycle_ctrl
package riscv_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } ctrl_state_t;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_RF    = 2'b10;
  localparam logic [1:0] ALU_IF    = 2'b11;
  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_TGT    = 2'b01;
  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_RS1  = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] WB_ALU    = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC4    = 2'b10;
  function automatic logic is_legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LUI, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL};
  endfunction
endpackage

// File: rtl/ctrl_perf_cnt.sv
// ctrl_perf_cnt: free-running cycle counter and retired-instruction counter, both wrapping
module ctrl_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt   <= cycle_cnt + CNT_W'(1);
      instret_cnt <= retire ? instret_cnt + CNT_W'(1) : instret_cnt;
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I-subset datapath with memory timeout.
// Define MC_CTRL_PERF_EN to add the cycle_cnt/instret_cnt performance counters.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16
`ifdef MC_CTRL_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic       illegal,
  output logic       mem_timeout,
  output logic [2:0] state_o
`ifdef MC_CTRL_PERF_EN
  , output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);
  import riscv_pkg::*;
  localparam int TW = $clog2(TIMEOUT + 2);
  ctrl_state_t state, state_n;
  logic [TW-1:0] wcnt;
  logic access, tmo, is_ld, is_st;
  assign access  = state inside {S_FETCH, S_MEM};
  assign is_ld   = opcode == OP_LOAD;
  assign is_st   = opcode == OP_STORE;
  assign state_o = state;
  // abort on the TIMEOUT-th consecutive wait cycle; a ready in that same cycle still completes
  assign tmo = (TIMEOUT != 0) && access && !mem_ready && wcnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      wcnt  <= (access && !mem_ready && !tmo) ? wcnt + TW'(1) : '0;
    end
  always_comb begin
    state_n     = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_INC;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_op      = ALU_ADD;
    reg_write   = 1'b0;
    mem_to_reg  = WB_ALU;
    illegal     = 1'b0;
    mem_timeout = tmo;
    case (state)
      S_IDLE: state_n = S_FETCH;
      S_FETCH: begin
        mem_req   = !tmo;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_n   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM;
        illegal   = !is_legal(opcode);
        state_n   = is_legal(opcode) ? S_EXEC : S_FETCH;
      end
      S_EXEC: begin
        state_n = S_WB;
        case (opcode)
          OP_R: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALU_RF;
          end
          OP_I: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_IF;
          end
          OP_LUI: begin
            alu_src_a = SRCA_ZERO;
            alu_src_b = SRCB_IMM;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            state_n   = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALU_BR;
            pc_write  = br_taken;
            pc_src    = PC_TGT;
            state_n   = S_FETCH;
          end
          OP_JAL: begin
            pc_write   = 1'b1;
            pc_src     = PC_TGT;
            reg_write  = 1'b1;
            mem_to_reg = WB_PC4;
            state_n    = S_FETCH;
          end
          default: state_n = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req = !tmo;
        iord    = 1'b1;
        mem_we  = is_st && !tmo;
        state_n = mem_ready ? (is_st ? S_FETCH : S_WB) : (tmo ? S_FETCH : S_MEM);
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_ld ? WB_MDR : WB_ALU;
        state_n    = S_FETCH;
      end
      default: state_n = S_IDLE;
    endcase
  end
`ifdef MC_CTRL_PERF_EN
  ctrl_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .retire      (state == S_WB || (state == S_MEM && is_st && mem_ready) ||
                  (state == S_EXEC && opcode inside {OP_BRANCH, OP_JAL})),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-cycle scoreboard of controller outputs against an instruction-level model
module tb_multicycle_ctrl;
  import riscv_pkg::*;
  localparam int TO = 4;
  logic clk = 0, rst_n = 0, mem_ready = 0, br_taken = 0;
  logic [6:0] opcode = '0;
  logic mem_req, mem_we, iord, ir_write, pc_write, reg_write, illegal, mem_timeout;
  logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, mem_to_reg;
  logic [2:0] state_o;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif
  multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .br_taken(br_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal(illegal),
    .mem_timeout(mem_timeout), .state_o(state_o)
`ifdef MC_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [2:0] st;
    logic req, we, iord, irw, pcw;
    logic [1:0] pcs, a, b, op;
    logic rw;
    logic [1:0] m2r;
    logic ill, tmo;
  } exp_t;
  typedef struct packed {
    exp_t e;
    logic [31:0] cc, ic;
  } rec_t;
  rec_t sb[$];
  int vectors = 0, miscompares = 0;
  int unsigned ecc = 0, eic = 0;
  bit pend = 0;
  function automatic logic rnd();
    return 1'($urandom);
  endfunction
  function automatic bit legal(input logic [6:0] op);
    return op == 7'b0110011 || op == 7'b0010011 || op == 7'b0110111 || op == 7'b0000011 ||
           op == 7'b0100011 || op == 7'b1100011 || op == 7'b1101111;
  endfunction
  // one clock of stimulus; the expected outputs and counter values for that cycle go to the scoreboard
  task automatic cyc(input logic rn, input logic [6:0] opc, input logic rdy, input logic br,
                     input exp_t e, input bit ret = 0);
    @(posedge clk);
    if (rst_n) begin
      ecc++;
      eic += pend;
    end
    pend = ret;
    #1;
    rst_n = rn; opcode = opc; mem_ready = rdy; br_taken = br;
    if (!rn) begin
      ecc = 0; eic = 0; pend = 0;
    end
    sb.push_back('{e, ecc, eic});
  endtask
  task automatic access(input logic [6:0] op, input exp_t b, input exp_t d, inout int waits,
                        output bit ok, input bit ret = 0);
    exp_t t;
    int k = 0;
    ok = 0;
    while (1) begin
      if (waits == 0) begin
        cyc(1, op, 1, rnd(), d, ret);
        ok = 1;
        return;
      end
      waits--;
      if (k == TO - 1) begin
        t = b; t.req = 0; t.we = 0; t.tmo = 1;
        cyc(1, op, 0, rnd(), t);
        return;
      end
      cyc(1, op, 0, rnd(), b);
      k++;
    end
  endtask
  task automatic instr(input logic [6:0] op, input int fw, input int mw, input logic br);
    exp_t b, d, e;
    bit ok, brj, ls;
    brj = op == OP_BRANCH || op == OP_JAL;
    ls  = op == OP_LOAD || op == OP_STORE;
    b = '{st:3'd1, req:1'b1, b:2'd2, default:'0};
    d = b; d.irw = 1; d.pcw = 1;
    do access(op, b, d, fw, ok); while (!ok);
    e = '{st:3'd2, b:2'd1, ill:!legal(op), default:'0};
    cyc(1, op, rnd(), rnd(), e);
    if (!legal(op)) return;
    e = '{st:3'd3, default:'0};
    case (op)
      OP_R:              begin e.a = 1; e.op = 2; end
      OP_I:              begin e.a = 1; e.b = 1; e.op = 3; end
      OP_LUI:            begin e.a = 2; e.b = 1; end
      OP_LOAD, OP_STORE: begin e.a = 1; e.b = 1; end
      OP_BRANCH:         begin e.a = 1; e.op = 1; e.pcw = br; e.pcs = 1; end
      default:           begin e.pcw = 1; e.pcs = 1; e.rw = 1; e.m2r = 2; end
    endcase
    cyc(1, op, rnd(), br, e, brj);
    if (brj) return;
    if (ls) begin
      b = '{st:3'd4, req:1'b1, iord:1'b1, we:(op == OP_STORE), default:'0};
      access(op, b, b, mw, ok, op == OP_STORE);
      if (!ok || op == OP_STORE) return;
    end
    e = '{st:3'd5, rw:1'b1, m2r:{1'b0, op == OP_LOAD}, default:'0};
    cyc(1, op, rnd(), rnd(), e, 1);
  endtask
  always @(negedge clk) begin : mon
    rec_t r;
    exp_t a;
    if (sb.size() != 0) begin
      r = sb.pop_front();
      a = {state_o, mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
           alu_op, reg_write, mem_to_reg, illegal, mem_timeout};
      vectors++;
      if (a !== r.e) begin
        miscompares++;
        $display("FAIL ctrl vec %0d: got %h expected %h (state got %0d expected %0d)",
                 vectors, a, r.e, state_o, r.e.st);
      end
`ifdef MC_CTRL_PERF_EN
      vectors++;
      if (cycle_cnt !== r.cc || instret_cnt !== r.ic) begin
        miscompares++;
        $display("FAIL perf vec %0d: got cyc=%0d ret=%0d expected cyc=%0d ret=%0d",
                 vectors, cycle_cnt, instret_cnt, r.cc, r.ic);
      end
`endif
    end
  end
  initial begin
    exp_t z, e;
    logic [6:0] ops[7] = '{OP_R, OP_I, OP_LUI, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL};
    logic [6:0] op;
    int fw, mw;
    z = '0;
    cyc(0, 0, 0, 0, z);
    cyc(0, 0, 0, 0, z);
    cyc(1, 0, 0, 0, z);
    instr(OP_R, 0, 0, 0);
    instr(OP_LOAD, 0, 3, 0);
    instr(OP_BRANCH, 0, 0, 1);
    instr(OP_BRANCH, 0, 0, 0);
    instr(7'h7f, 0, 0, 0);
    instr(OP_I, 4, 0, 0);
    instr(OP_STORE, 1, 4, 0);
    instr(OP_JAL, 0, 0, 0);
    instr(OP_LUI, 2, 0, 0);
    instr(OP_STORE, 0, 0, 0);
    // reset arriving while a store is waiting in MEM
    cyc(1, OP_STORE, 1, 0, '{st:3'd1, req:1'b1, b:2'd2, irw:1'b1, pcw:1'b1, default:'0});
    cyc(1, OP_STORE, 0, 0, '{st:3'd2, b:2'd1, default:'0});
    cyc(1, OP_STORE, 0, 0, '{st:3'd3, a:2'd1, b:2'd1, default:'0});
    cyc(1, OP_STORE, 0, 0, '{st:3'd4, req:1'b1, iord:1'b1, we:1'b1, default:'0});
    cyc(0, OP_STORE, 0, 0, z);
    cyc(0, OP_STORE, 1, 0, z);
    cyc(1, OP_STORE, 1, 0, z);
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 7) == 7) begin
        do op = 7'($urandom); while (legal(op));
      end else op = ops[$urandom_range(0, 6)];
      fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 9)) : int'($urandom_range(0, 2));
      mw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 9)) : int'($urandom_range(0, 2));
      instr(op, fw, mw, rnd());
    end
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
